output_arbiter: RTL
===================

OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 SHALL have parameter CREDIT_DEPTH, default 4, meaning downstream input-buffer depth in flits (range 1..7).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  5  per-input request for this output port (index N=0, E=1, W=2, S=3, L=4), driven by that input's routing logic.
REQ-005 SHALL have port flit_id  input  15  3-bit flit type at head of each input FIFO, input i at bits [3i+2:3i].
REQ-006 SHALL have port empty  input  5  input FIFO i empty.
REQ-007 SHALL have port credit_in  input  1  downstream freed one buffer slot this cycle.
REQ-008 SHALL have port grant  output  5  one-hot registered grant; all-zero when idle.
REQ-009 SHALL have port rd_en  output  5  combinational pop of input FIFO i.
REQ-010 SHALL have port sel  output  3  crossbar select, index of granted input; 0 when idle.
REQ-011 SHALL have port valid_out  output  1  flit forwarded downstream this cycle.
REQ-012 SHALL have port credit_cnt  output  3  current downstream credits.

Function
REQ-013 SHALL implement FSM with states IDLE and BUSY.
REQ-014 IDLE: candidate i = req[i] & ~empty[i] & flit_id[i]==HEADER; if any candidate, winner registered into grant/sel at next edge, state -> BUSY (grant latency 1 cycle).
REQ-015 IDLE: rd_en, valid_out SHALL be 0.
REQ-016 BUSY: transfer when ~empty[g] & credit_cnt>0 (g = granted index); transfer asserts rd_en[g] and valid_out in the same cycle.
REQ-017 BUSY: grant SHALL be held regardless of req[g] and of HEADER flits until a TAIL flit is transferred.
REQ-018 TAIL transfer: grant -> 0, sel -> 0, state -> IDLE at next edge; new grant no earlier than one cycle after that (1 idle cycle between packets).
REQ-019 BUSY, empty[g] or credit_cnt==0: no transfer, grant held (stall).
REQ-020 credit_cnt: -1 on transfer, +1 on credit_in; both same cycle -> unchanged; credit_in at CREDIT_DEPTH without transfer -> saturate, unchanged.
REQ-021 credit_cnt SHALL never underflow; at most one rd_en bit high per cycle.
REQ-022 Round-robin: search starts at (ptr+1) mod 5 and wraps; ptr updated to winner index on grant.

Reset
REQ-023 rst low SHALL immediately force grant=0, rd_en=0, sel=0, valid_out=0, state IDLE, ptr=4, credit_cnt=CREDIT_DEPTH.
REQ-024 Reset mid-packet SHALL abandon the packet; no grant resumption after release.
REQ-025 First arbitration after reset SHALL favour N (index 0).

Configuration
REQ-026 Macro OUTPUT_ARBITER_RR_EN defined: round-robin per REQ-022.
REQ-027 Macro undefined: fixed priority N>E>W>S>L; ptr not implemented; all other behaviour identical.

Structure
REQ-028 Shared package noc_pkg SHALL hold flit type encodings (HEADER, PAYLOAD, TAIL), port index constants N/E/W/S/L, and FSM state typedef.
REQ-029 Priority selection SHALL be a sub-module rr_arbiter (5-bit request, pointer in, one-hot grant out); fixed-priority mode uses it with pointer tied to 4.

Verification
REQ-030 Single packet: req=00001, N FIFO holds HEADER,PAYLOAD,TAIL -> grant=00001 cycle 1, valid_out cycles 1-3, grant=0 cycle 4, credit_cnt 4->1.
REQ-031 Contention (RR build): N and S request HEADER simultaneously, two packets each -> grant order N,S,N,S; fixed build -> N,N,S,S.
REQ-032 Credit stall: CREDIT_DEPTH=2, 4-flit packet, no credit_in -> 2 transfers then stall with grant held; one credit_in -> exactly one more transfer.
REQ-033 Simultaneous credit_in and transfer at credit_cnt=1 -> credit_cnt stays 1; credit_in at 4 idle -> stays 4.
REQ-034 Mid-packet empty and req drop on E -> grant stays 00010, no rd_en until FIFO refills; TAIL completes packet.
REQ-035 rst asserted mid-packet between edges -> grant, rd_en, valid_out 0 immediately; credit_cnt=4 after release.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encodings, port indices and arbiter FSM state.
package noc_pkg;

    localparam logic [2:0] HEADER  = 3'd1;
    localparam logic [2:0] PAYLOAD = 3'd2;
    localparam logic [2:0] TAIL    = 3'd3;

    localparam int unsigned NUM_PORTS = 5;

    localparam logic [2:0] PORT_N = 3'd0;
    localparam logic [2:0] PORT_E = 3'd1;
    localparam logic [2:0] PORT_W = 3'd2;
    localparam logic [2:0] PORT_S = 3'd3;
    localparam logic [2:0] PORT_L = 3'd4;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_BUSY = 1'b1;

    function automatic logic [2:0] onehot_to_idx(input logic [4:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Five-way priority selector: search starts one past i_ptr and wraps; one-hot result.
module rr_arbiter
    import noc_pkg::*;
(
    input  logic [4:0] i_req,
    input  logic [2:0] i_ptr,
    output logic [4:0] o_grant
);

    logic        w_found;
    int unsigned w_idx;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            w_idx = (int'(i_ptr) + k) % NUM_PORTS;
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_arbiter.sv
// Output-port packet arbiter with downstream credit tracking.
// Define OUTPUT_ARBITER_RR_EN for round-robin; otherwise fixed priority N>E>W>S>L.
module output_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned CREDIT_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  req,
    input  logic [14:0] flit_id,
    input  logic [4:0]  empty,
    input  logic        credit_in,
    output logic [4:0]  grant,
    output logic [4:0]  rd_en,
    output logic [2:0]  sel,
    output logic        valid_out,
    output logic [2:0]  credit_cnt
);

    localparam logic [2:0] LP_DEPTH = 3'(CREDIT_DEPTH);

    state_t     r_state;
    logic [4:0] r_grant;
    logic [2:0] r_sel;
    logic [2:0] r_credit;

    logic [4:0] w_cand;
    logic [4:0] w_win;
    logic [2:0] w_ptr;
    logic [2:0] w_head;
    logic       w_gempty;
    logic       w_xfer;

    always_comb begin
        w_cand = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            w_cand[i] = req[i] & ~empty[i] & (flit_id[3*i +: 3] == HEADER);
        end
    end

`ifdef OUTPUT_ARBITER_RR_EN
    logic [2:0] r_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= PORT_L;
        end else if (r_state == ST_IDLE && |w_cand) begin
            r_ptr <= onehot_to_idx(w_win);
        end
    end

    assign w_ptr = r_ptr;
`else
    // Pointer at L makes the search start at N, giving fixed N>E>W>S>L.
    assign w_ptr = PORT_L;
`endif

    rr_arbiter u_rr_arbiter (
        .i_req   (w_cand),
        .i_ptr   (w_ptr),
        .o_grant (w_win)
    );

    always_comb begin
        w_head   = '0;
        w_gempty = 1'b1;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (r_sel == 3'(i)) begin
                w_head   = flit_id[3*i +: 3];
                w_gempty = empty[i];
            end
        end
    end

    assign w_xfer = (r_state == ST_BUSY) & ~w_gempty & (r_credit != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_sel   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_cand) begin
                        r_grant <= w_win;
                        r_sel   <= onehot_to_idx(w_win);
                        r_state <= ST_BUSY;
                    end
                end
                default: begin
                    if (w_xfer && w_head == TAIL) begin
                        r_grant <= '0;
                        r_sel   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_credit <= LP_DEPTH;
        end else begin
            case ({w_xfer, credit_in})
                2'b10:   r_credit <= r_credit - 3'd1;
                2'b01:   if (r_credit < LP_DEPTH) r_credit <= r_credit + 3'd1;
                default: r_credit <= r_credit;
            endcase
        end
    end

    assign grant      = r_grant;
    assign sel        = r_sel;
    assign credit_cnt = r_credit;
    assign valid_out  = w_xfer;
    assign rd_en      = w_xfer ? r_grant : '0;

endmodule
